// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch and
// the data (load/store) stage. Data has priority; an access in flight is never
// pre-empted. The memory handshake is registered and held until mem_ack.
// Optional feature macro: MEM_ARB_TIMEOUT_EN (abort an access that waits TIMEOUT
// cycles, return all-ones data and set the sticky mem_err flag).
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  // Fetch port
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  // Data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  // Memory side
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  // Pipeline stalls and status
  output logic              stall_f,
  output logic              stall_m,
  output logic              mem_err
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StData  = 2'd1,
    StInstr = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                i_done_q, i_done_d;
  logic                d_done_q, d_done_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  logic                d_elig;
  logic                i_elig;
  logic                timeout_hit;

  // A port whose done is high this cycle is still holding its old request;
  // masking it prevents issuing the same access twice.
  assign d_elig = d_req & ~d_done_q;
  assign i_elig = i_req & ~i_done_q;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CntRawW = $clog2(TIMEOUT + 1);
  localparam int unsigned CntW    = (CntRawW < 8) ? 8 : CntRawW;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mem_err_q, mem_err_d;

  // Abort on the TIMEOUT-th wait cycle that still has no acknowledge.
  assign timeout_hit = (state_q != StIdle) && !mem_ack && (cnt_q == CntW'(TIMEOUT - 1));

  // Wait-cycle counter: held at zero in idle so every access starts from zero.
  always_comb begin
    cnt_d     = cnt_q;
    mem_err_d = mem_err_q | timeout_hit;
    if (state_q == StIdle) begin
      cnt_d = '0;
    end else if (cnt_q != CntW'(TIMEOUT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter and sticky error flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;
`else
  // Without the timeout feature the FSM waits for mem_ack indefinitely.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT;
  assign timeout_hit        = 1'b0;
  assign mem_err            = 1'b0;
`endif

  // Next-state and registered-output logic of the arbitration FSM.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // mem_ack arriving here belongs to no access and is ignored.
        if (d_elig) begin
          state_d     = StData;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
        end else if (i_elig) begin
          state_d     = StInstr;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = i_addr;
          mem_wdata_d = '0;
        end
      end

      StData: begin
        if (mem_ack) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          d_done_d  = 1'b1;
          // Stores complete without touching the last load result.
          if (!mem_we_q) begin
            d_rdata_d = mem_rdata;
          end
        end else if (timeout_hit) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          d_done_d  = 1'b1;
          d_rdata_d = '1;
        end
      end

      StInstr: begin
        if (mem_ack) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          i_done_d  = 1'b1;
          i_rdata_d = mem_rdata;
        end else if (timeout_hit) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          i_done_d  = 1'b1;
          i_rdata_d = '1;
        end
      end

      default: begin
        state_d   = StIdle;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

  // Stalls are combinational so the pipeline freezes in the request cycle itself.
  assign stall_m = d_req & ~d_done_q;
  assign stall_f = (i_req & ~i_done_q) | stall_m;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: random memory latency model, port drivers,
// and a scoreboard monitor that checks completions against a reference model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_done;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_done;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall_f, stall_m, mem_err;

  mem_port_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_done    (i_done),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_done    (d_done),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .stall_f   (stall_f),
    .stall_m   (stall_m),
    .mem_err   (mem_err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Fetch addresses live below 0x100, data addresses in 0x100..0x3FC, so
  // instruction words are never overwritten by stores.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C22_0004;
    return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
  endfunction

  logic [31:0] ref_mem  [logic [31:0]];  // data-port view of memory
  logic [31:0] back_mem [logic [31:0]];  // memory model storage
  logic [31:0] exp_i_q[$];
  logic [31:0] exp_d_q[$];
  logic [31:0] hold_i    = '0;  // value i_rdata must show now
  logic [31:0] hold_d    = '0;  // value d_rdata must show now
  logic [31:0] last_load = '0;  // d_rdata after all issued data accesses

  function automatic logic [31:0] rd_ref(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // Current request of each driver, compared against the issued access.
  logic [31:0] cur_i_addr  = '0;
  logic        cur_d_we    = 1'b0;
  logic [31:0] cur_d_addr  = '0;
  logic [31:0] cur_d_wdata = '0;

  // Event log used by directed timing checks.
  bit          acc_port[$];  // 1 = data, 0 = fetch
  int unsigned acc_cyc[$];
  int unsigned i_done_cyc = 0;
  int unsigned d_done_cyc = 0;
  int          stall_f_cnt = 0;

  // ---------------- memory model + monitor ----------------
  int          lat_force = -1;
  bit          stray_ack = 1'b0;
  bit          done_chk  = 1'b1;
  bit          acc_open  = 1'b0;
  int          wait_left = 0;
  bit          cap_is_d, cap_we;
  logic [31:0] cap_addr, cap_wdata;
  bit          exp_i_next = 0, exp_d_next = 0;
  bit          prev_dec_d = 0, prev_dec_i = 0, prev_mem_req = 0;
  bit          exp_issue = 0, ack_prev = 0, new_acc;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        acc_open = 0; exp_i_next = 0; exp_d_next = 0; exp_issue = 0; ack_prev = 0;
        prev_dec_d = 0; prev_dec_i = 0; prev_mem_req = 0;
        mem_ack = 1'b0;
      end else begin
        // Completions: exact latency, data routing, and hold of rdata.
        if (done_chk) begin
          chk("i_done_timing", i_done, exp_i_next);
          chk("d_done_timing", d_done, exp_d_next);
        end
        if (i_done) begin
          if (exp_i_q.size() == 0) chk("i_done_unexpected", i_done, 1'b0);
          else begin hold_i = exp_i_q.pop_front(); i_done_cyc = cyc; end
        end
        if (d_done) begin
          if (exp_d_q.size() == 0) chk("d_done_unexpected", d_done, 1'b0);
          else begin hold_d = exp_d_q.pop_front(); d_done_cyc = cyc; end
        end
        chk("i_rdata", i_rdata, hold_i);
        chk("d_rdata", d_rdata, hold_d);
        chk("stall_m", stall_m, d_req && !d_done);
        chk("stall_f", stall_f, (i_req && !i_done) || (d_req && !d_done));
        if (stall_f) stall_f_cnt++;

        // Memory side: priority, issued fields, stability, release after ack.
        if (ack_prev) chk("mem_req_release", mem_req, 1'b0);
        new_acc = mem_req && !prev_mem_req;
        if (exp_issue) chk("issue_after_one_idle", new_acc, 1'b1);
        if (new_acc) begin
          if (!prev_dec_d && !prev_dec_i) chk("issue_without_request", mem_req, 1'b0);
          cap_is_d = prev_dec_d;
          if (prev_dec_d) begin
            chk("issue_d_we", mem_we, cur_d_we);
            chk("issue_d_addr", mem_addr, cur_d_addr);
            chk("issue_d_wdata", mem_wdata, cur_d_wdata);
          end else begin
            chk("issue_i_addr", mem_addr, cur_i_addr);
            chk("issue_i_we", mem_we, 1'b0);
            chk("issue_i_wdata", mem_wdata, 32'h0);
          end
          acc_port.push_back(prev_dec_d);
          acc_cyc.push_back(cyc);
          cap_we = mem_we; cap_addr = mem_addr; cap_wdata = mem_wdata;
          acc_open  = 1;
          wait_left = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 3));
        end else if (mem_req) begin
          chk("hold_mem_addr", mem_addr, cap_addr);
          chk("hold_mem_we", mem_we, cap_we);
          chk("hold_mem_wdata", mem_wdata, cap_wdata);
        end

        // Drive the memory response for the coming edge.
        exp_i_next = 0; exp_d_next = 0; ack_prev = 0;
        mem_ack    = 1'b0;
        mem_rdata  = $urandom;
        if (!mem_req) acc_open = 0;
        if (stray_ack) begin
          mem_ack   = 1'b1;
          stray_ack = 0;
        end else if (acc_open) begin
          if (wait_left == 0) begin
            mem_ack = 1'b1;
            if (cap_we) back_mem[cap_addr] = cap_wdata;
            else mem_rdata = back_mem.exists(cap_addr) ? back_mem[cap_addr] : init_word(cap_addr);
            acc_open = 0;
            ack_prev = 1;
            if (cap_is_d) exp_d_next = 1; else exp_i_next = 1;
          end else begin
            wait_left--;
          end
        end
        prev_dec_d   = d_req && !d_done;
        prev_dec_i   = i_req && !i_done;
        prev_mem_req = mem_req;
        exp_issue    = (i_done || d_done) && (prev_dec_d || prev_dec_i);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic do_fetch(input logic [31:0] a);
    int n = 0;
    cur_i_addr = a; i_addr = a; i_req = 1'b1;
    exp_i_q.push_back(init_word(a));
    do begin @(posedge clk); #1; n++; end while (!i_done && n < 200);
    if (!i_done) begin chk("i_done_wait", i_done, 1'b1); exp_i_q.delete(); end
    i_req = 1'b0; i_addr = $urandom;
  endtask

  task automatic do_data(input logic we, input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    cur_d_we = we; cur_d_addr = a; cur_d_wdata = wd;
    d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1;
    if (we) begin
      exp_d_q.push_back(last_load);
      ref_mem[a] = wd;
    end else begin
      last_load = rd_ref(a);
      exp_d_q.push_back(last_load);
    end
    do begin @(posedge clk); #1; n++; end while (!d_done && n < 200);
    if (!d_done) begin chk("d_done_wait", d_done, 1'b1); exp_d_q.delete(); end
    d_req = 1'b0; d_we = $urandom; d_addr = $urandom; d_wdata = $urandom;
  endtask

  task automatic apply_reset();
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    hold_i = '0; hold_d = '0; last_load = '0;
    exp_i_q.delete(); exp_d_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_mem_req"}, mem_req, 1'b0);
    chk({tag, "_mem_we"}, mem_we, 1'b0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_i_done"}, i_done, 1'b0);
    chk({tag, "_d_done"}, d_done, 1'b0);
    chk({tag, "_i_rdata"}, i_rdata, 32'h0);
    chk({tag, "_d_rdata"}, d_rdata, 32'h0);
    chk({tag, "_mem_err"}, mem_err, 1'b0);
    chk({tag, "_stalls"}, {stall_f, stall_m}, 2'b00);
  endtask

  task automatic clear_log();
    acc_port.delete(); acc_cyc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  int unsigned t0;

  initial begin
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk); #1;
    check_reset_vals("reset");

    // Single fetch with a 3-cycle memory wait.
    lat_force = 3; clear_log();
    @(posedge clk); #1;
    t0 = cyc; stall_f_cnt = 0;
    do_fetch(32'h40);
    @(negedge clk); #1;
    chk("t1_access_count", acc_cyc.size(), 1);
    if (acc_cyc.size() >= 1) chk("t1_mem_req_cycle", acc_cyc[0] - t0, 1);
    chk("t1_done_cycle", i_done_cyc - t0, 5);
    chk("t1_i_rdata", i_rdata, 32'h8C22_0004);
    chk("t1_stall_f_cycles", stall_f_cnt, 5);

    // Simultaneous load and fetch: data first, one idle cycle, then fetch.
    lat_force = 1; clear_log();
    @(posedge clk); #1;
    t0 = cyc;
    fork
      do_data(1'b0, 32'h100, 32'h0);
      do_fetch(32'h44);
    join
    @(negedge clk); #1;
    chk("t2_access_count", acc_port.size(), 2);
    if (acc_port.size() >= 2) begin
      chk("t2_first_is_data", acc_port[0], 1'b1);
      chk("t2_second_is_fetch", acc_port[1], 1'b0);
      chk("t2_data_issue", acc_cyc[0] - t0, 1);
      chk("t2_fetch_issue", acc_cyc[1] - t0, 4);
    end
    chk("t2_d_done_cycle", d_done_cyc - t0, 3);
    chk("t2_i_done_cycle", i_done_cyc - t0, 6);
    chk("t2_d_rdata", d_rdata, init_word(32'h100));

    // Store: d_rdata keeps the previous load result.
    lat_force = 2; clear_log();
    @(posedge clk); #1;
    do_data(1'b1, 32'h200, 32'hCAFE_F00D);
    @(negedge clk); #1;
    chk("t3_store_keeps_d_rdata", d_rdata, init_word(32'h100));
    chk("t3_store_written", back_mem.exists(32'h200) ? back_mem[32'h200] : 32'h0, 32'hCAFE_F00D);
    chk("t3_access_count", acc_port.size(), 1);

    // Data request raised while a fetch waits: no pre-emption.
    lat_force = 4; clear_log();
    @(posedge clk); #1;
    t0 = cyc;
    fork
      do_fetch(32'h48);
      begin
        repeat (2) begin @(posedge clk); #1; end
        do_data(1'b0, 32'h200, 32'h0);
      end
    join
    @(negedge clk); #1;
    chk("t4_access_count", acc_port.size(), 2);
    if (acc_port.size() >= 2) begin
      chk("t4_fetch_first", acc_port[0], 1'b0);
      chk("t4_data_second", acc_port[1], 1'b1);
      chk("t4_data_issue", acc_cyc[1] - t0, 7);
    end
    chk("t4_i_done_cycle", i_done_cyc - t0, 6);
    chk("t4_load_after_store", d_rdata, 32'hCAFE_F00D);

    // Reset two cycles into a data access, then a stray mem_ack.
    lat_force = 50; clear_log();
    @(posedge clk); #1;
    cur_d_we = 1'b0; cur_d_addr = 32'h108; cur_d_wdata = 32'h0;
    d_we = 1'b0; d_addr = 32'h108; d_wdata = 32'h0; d_req = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("t5_in_flight", mem_req, 1'b1);
    apply_reset();
    stray_ack = 1'b1;
    @(negedge clk); #1;
    check_reset_vals("t5");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk("t5_stays_idle", mem_req, 1'b0);
    end
    chk("t5_access_count", acc_port.size(), 1);

`ifdef MEM_ARB_TIMEOUT_EN
    // No acknowledge: abort after TIMEOUT wait cycles with all-ones data.
    lat_force = 50; done_chk = 1'b0;
    @(posedge clk); #1;
    t0 = cyc;
    cur_d_we = 1'b0; cur_d_addr = 32'h10C; cur_d_wdata = 32'h0;
    d_we = 1'b0; d_addr = 32'h10C; d_req = 1'b1;
    last_load = '1; exp_d_q.push_back(32'hFFFF_FFFF);
    begin
      int n = 0;
      do begin @(posedge clk); #1; n++; end while (!d_done && n < 50);
      chk("t6_done_seen", d_done, 1'b1);
    end
    d_req = 1'b0;
    @(negedge clk); #1;
    chk("t6_done_cycle", d_done_cyc - t0, 5);
    chk("t6_d_rdata", d_rdata, 32'hFFFF_FFFF);
    chk("t6_mem_err", mem_err, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    chk("t6_mem_err_sticky", mem_err, 1'b1);
    apply_reset();
    @(negedge clk); #1;
    chk("t6_mem_err_cleared", mem_err, 1'b0);
    done_chk = 1'b1;
`endif

    // Random concurrent traffic with random memory latency.
    lat_force = -1;
    fork
      for (int k = 0; k < 60; k++) begin
        repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
        do_fetch(32'($urandom_range(0, 63)) << 2);
      end
      for (int j = 0; j < 60; j++) begin
        repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
        if ($urandom_range(0, 1) == 1)
          do_data(1'b1, 32'h100 + (32'($urandom_range(0, 191)) << 2), $urandom);
        else
          do_data(1'b0, 32'h100 + (32'($urandom_range(0, 191)) << 2), 32'h0);
      end
    join
    repeat (3) @(negedge clk);
    #1;
    chk("end_i_queue_empty", exp_i_q.size(), 0);
    chk("end_d_queue_empty", exp_d_q.size(), 0);
    chk("end_mem_err", mem_err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
